// File: rtl/adc_volt_display_if.sv
// Handshake and display bus between an ADC-code producer and adc_volt_display.
// The master drives the code strobe; the slave returns status, BCD digits and the 7-seg drive.
interface adc_volt_display_if;
  logic [11:0] code_in;
  logic        code_valid;
  logic        busy;
  logic [15:0] digits;
  logic [7:0]  seg;
  logic [3:0]  ans;

  modport master (
    output code_in,
    output code_valid,
    input  busy,
    input  digits,
    input  seg,
    input  ans
  );

  modport slave (
    input  code_in,
    input  code_valid,
    output busy,
    output digits,
    output seg,
    output ans
  );
endinterface

// File: rtl/adc_volt_display.sv
// Converts a 12-bit unipolar XADC code to millivolts, then to BCD by double-dabble,
// and scans the result onto a 4-digit active-low 7-segment display as "U.ddd".
module adc_volt_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic               DCLK,
  input  logic               RESET_N,
  adc_volt_display_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_BCD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [11:0]   code_q, code_d;
  logic [9:0]    mv_q, mv_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [3:0]    iter_q, iter_d;
  logic [15:0]   digits_q, digits_d;
  logic [21:0]   product;
  logic [11:0]   bcd_adj;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    ans_q, ans_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    nib;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // code*1000 as shift-and-subtract; max 4095*1000 fits in 22 bits
  assign product = ({10'd0, code_q} << 10) - ({10'd0, code_q} << 4) - ({10'd0, code_q} << 3);
  assign bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    mv_d     = mv_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    digits_d = digits_q;
    case (state_q)
      S_IDLE: begin
        if (bus.code_valid) begin
          code_d  = bus.code_in;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        mv_d    = product[21:12];
        bcd_d   = 12'd0;
        iter_d  = 4'd0;
        state_d = S_BCD;
      end
      S_BCD: begin
        bcd_d  = {bcd_adj[10:0], mv_q[9]};
        mv_d   = {mv_q[8:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd9) begin
          state_d = S_DONE;
        end
      end
      default: begin
        digits_d = {4'h0, bcd_q};
        state_d  = S_IDLE;
      end
    endcase
  end

  // Scan path is computed from next-state select and digits so seg/ans move together
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    sel_d = sel_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sel_d = sel_q + 2'd1;
    end
    case (sel_d)
      2'd0:    nib = digits_d[3:0];
      2'd1:    nib = digits_d[7:4];
      2'd2:    nib = digits_d[11:8];
      default: nib = digits_d[15:12];
    endcase
    ans_d = ~(4'b0001 << sel_d);
    seg_d = {(sel_d != 2'd3), dec7(nib)};
  end

  always_ff @(posedge DCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      code_q   <= 12'd0;
      mv_q     <= 10'd0;
      bcd_q    <= 12'd0;
      iter_q   <= 4'd0;
      digits_q <= 16'h0000;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      ans_q    <= 4'b1110;
      seg_q    <= 8'hC0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      mv_q     <= mv_d;
      bcd_q    <= bcd_d;
      iter_q   <= iter_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      ans_q    <= ans_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.digits = digits_q;
  assign bus.seg    = seg_q;
  assign bus.ans    = ans_q;

endmodule

// File: tb/tb_adc_volt_display.sv
// Directed plus randomized bench for adc_volt_display against an arithmetic reference model.
module tb_adc_volt_display;

  localparam int RDIV = 4;

  logic        DCLK = 1'b0;
  logic        RESET_N;
  int          n_vec = 0;
  int          n_err = 0;
  int          scan_cyc;
  logic [15:0] model_digits;
  logic [6:0]  seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  adc_volt_display_if bus ();

  adc_volt_display #(.REFRESH_DIV(RDIV)) dut (
    .DCLK    (DCLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 DCLK = ~DCLK;

  always @(posedge DCLK or negedge RESET_N) begin
    if (!RESET_N) scan_cyc <= 0;
    else          scan_cyc <= scan_cyc + 1;
  end

  function automatic logic [15:0] ref_digits(input logic [11:0] c);
    int mv;
    mv = (int'(c) * 1000) / 4096;
    return {4'h0, 4'(mv / 100), 4'((mv / 10) % 10), 4'(mv % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_scan(input int ncyc);
    int sel;
    logic [3:0] n;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge DCLK);
      sel = (scan_cyc / RDIV) % 4;
      n   = model_digits[sel*4 +: 4];
      chk("scan_ans", {28'd0, bus.ans}, {28'd0, ~(4'b0001 << sel)});
      chk("scan_seg", {24'd0, bus.seg}, {24'd0, (sel != 3), seg_tbl[n]});
    end
  endtask

  task automatic convert(input logic [11:0] c, input bit inject);
    int hi;
    logic [15:0] exp;
    logic [15:0] prev;
    exp  = ref_digits(c);
    prev = model_digits;
    @(negedge DCLK);
    bus.code_in    = c;
    bus.code_valid = 1'b1;
    hi = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge DCLK);
      if (k == 12) chk("digits_hold", {16'd0, bus.digits}, {16'd0, prev});
      if (!bus.busy) begin
        chk("digits_done", {16'd0, bus.digits}, {16'd0, exp});
        bus.code_valid = 1'b0;
        break;
      end
      hi++;
      bus.code_valid = inject && (k == 5 || k == 12);
      bus.code_in    = bus.code_valid ? 12'h100 : 12'($urandom);
    end
    chk("busy_len", hi, 12);
    model_digits = exp;
  endtask

  initial begin
    RESET_N        = 1'b0;
    bus.code_in    = 12'd0;
    bus.code_valid = 1'b0;
    model_digits   = 16'h0000;
    repeat (2) @(negedge DCLK);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_digits", {16'd0, bus.digits}, 32'h0000);
    chk("rst_ans",    {28'd0, bus.ans}, 32'hE);
    chk("rst_seg",    {24'd0, bus.seg}, 32'hC0);
    RESET_N = 1'b1;
    check_scan(8);

    convert(12'hE3E, 1'b0);
    convert(12'hFFF, 1'b0);
    convert(12'h800, 1'b0);
    convert(12'h000, 1'b0);
    convert(12'h001, 1'b0);
    convert(12'hE3E, 1'b1);
    check_scan(20);

    for (int i = 0; i < 12; i++) begin
      convert(12'($urandom_range(0, 4095)), 1'($urandom % 2));
    end
    check_scan(8);

    @(negedge DCLK);
    bus.code_in    = 12'hFFF;
    bus.code_valid = 1'b1;
    @(negedge DCLK);
    bus.code_valid = 1'b0;
    repeat (5) @(negedge DCLK);
    RESET_N = 1'b0;
    #1;
    model_digits = 16'h0000;
    chk("abort_busy",   {31'd0, bus.busy}, 32'd0);
    chk("abort_digits", {16'd0, bus.digits}, 32'h0000);
    chk("abort_ans",    {28'd0, bus.ans}, 32'hE);
    chk("abort_seg",    {24'd0, bus.seg}, 32'hC0);
    @(negedge DCLK);
    RESET_N = 1'b1;
    repeat (20) @(negedge DCLK);
    chk("post_busy",   {31'd0, bus.busy}, 32'd0);
    chk("post_digits", {16'd0, bus.digits}, 32'h0000);
    check_scan(8);
    convert(12'hE3E, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
